// File: rtl/uart_resp_pkg.sv
// Shared constants and state encoding for the UART register responder.
package uart_resp_pkg;

    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam int         CMD_WR_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GET_DATA = 2'd1,
        ST_SEND     = 2'd2,
        ST_SEND_CK  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_reg_responder_if.sv
// FIFO-side handshake bundle: RX pop path and TX push path of the UART core.
interface uart_reg_responder_if;

    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;

    // The responder initiates every pop and push, so it owns the master side.
    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, wr_uart, w_data
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, wr_uart, w_data
    );

endinterface

// File: rtl/uart_resp_timeout.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYC-1.
module uart_resp_timeout #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Holds at terminal count so the flag stays up until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_reg_responder.sv
// Serial register-access responder: pops commands from the RX FIFO, replies via the TX FIFO.
// Optional feature macro UART_RESP_CKSUM_EN appends an XOR checksum byte after each reply.
module uart_reg_responder
    import uart_resp_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_reg_responder_if.master    fifo,
    output logic [8*NUM_REGS-1:0]   regs_q,
    output logic                    busy,
    output logic [7:0]              err_cnt
);

    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                  state_q, state_d;
    logic [6:0]              addr_q, addr_d;
    logic [7:0]              reply_q, reply_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [8*NUM_REGS-1:0]   regs_d;
    logic                    nak;
    logic                    tmr_clear;
    logic                    tmr_enable;
    logic                    tmr_tc;
`ifdef UART_RESP_CKSUM_EN
    logic [7:0]              cksum_q, cksum_d;
`endif

    function automatic logic addr_ok(input logic [6:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    uart_resp_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .tc     (tmr_tc)
    );

    assign fifo.rd_uart = reset && (state_q == ST_IDLE || state_q == ST_GET_DATA) && !fifo.rx_empty;
    assign fifo.wr_uart = reset && (state_q == ST_SEND || state_q == ST_SEND_CK) && !fifo.tx_full;
    assign fifo.w_data  = reply_q;
    assign busy         = reset && (state_q != ST_IDLE);
    assign err_cnt      = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reply_d    = reply_q;
        regs_d     = regs_q;
        err_cnt_d  = err_cnt_q;
        nak        = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
`ifdef UART_RESP_CKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo.rx_empty) begin
                    addr_d = fifo.r_data[6:0];
`ifdef UART_RESP_CKSUM_EN
                    cksum_d = fifo.r_data;
`endif
                    if (fifo.r_data[CMD_WR_BIT]) begin
                        state_d   = ST_GET_DATA;
                        tmr_clear = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        if (addr_ok(fifo.r_data[6:0])) begin
                            reply_d = regs_q[8*int'(fifo.r_data[ADDR_W-1:0]) +: 8];
                        end else begin
                            reply_d = NAK;
                            nak     = 1'b1;
                        end
                    end
                end
            end
            ST_GET_DATA: begin
                // An arriving data byte takes priority over a simultaneous timeout.
                if (!fifo.rx_empty) begin
                    state_d = ST_SEND;
`ifdef UART_RESP_CKSUM_EN
                    cksum_d = cksum_q ^ fifo.r_data;
`endif
                    if (addr_ok(addr_q)) begin
                        regs_d[8*int'(addr_q[ADDR_W-1:0]) +: 8] = fifo.r_data;
                        reply_d = ACK;
                    end else begin
                        reply_d = NAK;
                        nak     = 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d = ST_SEND;
                    reply_d = NAK;
                    nak     = 1'b1;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_SEND: begin
                if (!fifo.tx_full) begin
`ifdef UART_RESP_CKSUM_EN
                    reply_d = cksum_q ^ reply_q;
                    state_d = ST_SEND_CK;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_SEND_CK: begin
                if (!fifo.tx_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (nak && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            reply_q   <= '0;
            err_cnt_q <= '0;
            regs_q    <= '0;
`ifdef UART_RESP_CKSUM_EN
            cksum_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            reply_q   <= reply_d;
            err_cnt_q <= err_cnt_d;
            regs_q    <= regs_d;
`ifdef UART_RESP_CKSUM_EN
            cksum_q   <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed, table-driven bench for uart_reg_responder with a queue-based RX/TX FIFO model.
module tb_uart_reg_responder;

    localparam int NUM_REGS = 8;
    localparam int TO_CYC   = 16;
`ifdef UART_RESP_CKSUM_EN
    localparam int RPC = 2;
`else
    localparam int RPC = 1;
`endif

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       two;
        logic [7:0] reply;
        logic [7:0] err;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [8*NUM_REGS-1:0] regs_q;
    logic                  busy;
    logic [7:0]            err_cnt;

    always #5 clk = ~clk;

    uart_reg_responder_if u_if ();

    uart_reg_responder #(.NUM_REGS(NUM_REGS), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk     (clk),
        .reset   (reset),
        .fifo    (u_if.master),
        .regs_q  (regs_q),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    logic [7:0]            rx_q [$];
    logic [7:0]            tx_q [$];
    logic [7:0]            exp_q [$];
    logic [8*NUM_REGS-1:0] model_regs;
    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    int exp_pops = 0;
    int chk_idx = 0;
    int overlap_cnt = 0;
    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_rx();
        u_if.rx_empty = (rx_q.size() == 0);
        u_if.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // One clock: sample strobes mid-cycle, then update the FIFO model after the edge.
    task automatic tick();
        logic       popped;
        logic       pushed;
        logic [7:0] pd;
        @(negedge clk);
        popped = u_if.rd_uart;
        pushed = u_if.wr_uart;
        pd     = u_if.w_data;
        if (popped && pushed) overlap_cnt++;
        @(posedge clk);
        #1;
        if (popped && rx_q.size() > 0) begin
            rx_q.delete(0);
            pop_cnt++;
        end
        if (pushed) tx_q.push_back(pd);
        drive_rx();
    endtask

    task automatic run_until(input int n, output int k);
        k = 0;
        while (tx_q.size() < n && k < 60) begin
            tick();
            k++;
        end
    endtask

    task automatic add_exp(input logic [7:0] b0, input logic [7:0] b1, input logic two,
                           input logic [7:0] reply);
        exp_q.push_back(reply);
`ifdef UART_RESP_CKSUM_EN
        exp_q.push_back(b0 ^ (two ? b1 : 8'h00) ^ reply);
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        rx_q.push_back(v.b0);
        if (v.two) rx_q.push_back(v.b1);
        drive_rx();
        exp_pops += v.two ? 2 : 1;
        add_exp(v.b0, v.b1, v.two, v.reply);
        if (v.b0[7] && int'(v.b0[6:0]) < NUM_REGS)
            model_regs[8*int'(v.b0[2:0]) +: 8] = v.b1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_err);
        logic [7:0] got;
        check({name, "_txcount"}, 64'(tx_q.size()), 64'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            got = 8'hxx;
            if (i < tx_q.size()) got = tx_q[i];
            check({name, "_txbyte"}, 64'(got), 64'(exp_q[i]));
        end
        chk_idx = exp_q.size();
        check({name, "_err"}, 64'(err_cnt), 64'(exp_err));
        check({name, "_regs"}, 64'(regs_q), 64'(model_regs));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_pops"}, 64'(pop_cnt), 64'(exp_pops));
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        int k;
        applyStimulus(v);
        run_until(exp_q.size(), k);
        check({name, "_latency"}, 64'(k), 64'((v.two ? 2 : 1) + RPC));
        checkOutput(name, v.err);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int stall_bad;

        vecs[0]  = '{8'h83, 8'h5A, 1'b1, 8'h06, 8'd0};
        vecs[1]  = '{8'h03, 8'h00, 1'b0, 8'h5A, 8'd0};
        vecs[2]  = '{8'h09, 8'h00, 1'b0, 8'h15, 8'd1};
        vecs[3]  = '{8'h8A, 8'h11, 1'b1, 8'h15, 8'd2};
        vecs[4]  = '{8'h87, 8'hC3, 1'b1, 8'h06, 8'd2};
        vecs[5]  = '{8'h07, 8'h00, 1'b0, 8'hC3, 8'd2};
        vecs[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'd2};
        vecs[7]  = '{8'h80, 8'hFF, 1'b1, 8'h06, 8'd2};
        vecs[8]  = '{8'h7F, 8'h00, 1'b0, 8'h15, 8'd3};
        vecs[9]  = '{8'hFF, 8'h01, 1'b1, 8'h15, 8'd4};
        vecs[10] = '{8'h08, 8'h00, 1'b0, 8'h15, 8'd5};
        vecs[11] = '{8'h00, 8'h00, 1'b0, 8'hFF, 8'd5};

        model_regs    = '0;
        reset         = 1'b0;
        u_if.tx_full  = 1'b0;
        rx_q.push_back(8'h03);
        drive_rx();

        // Reset with a byte waiting: nothing may be popped or pushed.
        tick();
        @(negedge clk);
        check("rst_rd_uart", 64'(u_if.rd_uart), 64'(0));
        check("rst_wr_uart", 64'(u_if.wr_uart), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        tick();
        rx_q.delete();
        drive_rx();
        reset = 1'b1;
        tick();
        tick();
        check("rst_pops", 64'(pop_cnt), 64'(0));
        check("rst_regs", 64'(regs_q), 64'(0));
        check("rst_err", 64'(err_cnt), 64'(0));
        check("rst_tx", 64'(tx_q.size()), 64'(0));

        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        end

        // TX back-pressure on a read with a second command queued behind it.
        u_if.tx_full = 1'b1;
        rx_q.push_back(8'h03);
        rx_q.push_back(8'h07);
        drive_rx();
        tick();
        exp_pops += 1;
        stall_bad = 0;
        repeat (20) begin
            tick();
            if (u_if.w_data !== 8'h5A) stall_bad++;
        end
        check("stall_wdata", 64'(stall_bad), 64'(0));
        check("stall_nopush", 64'(tx_q.size()), 64'(chk_idx));
        check("stall_pops", 64'(pop_cnt), 64'(exp_pops));
        u_if.tx_full = 1'b0;
        add_exp(8'h03, 8'h00, 1'b0, 8'h5A);
        add_exp(8'h07, 8'h00, 1'b0, 8'hC3);
        exp_pops += 1;
        run_until(exp_q.size(), k);
        checkOutput("stall", 8'd5);

        // Write with no data byte: NAK after TO_CYC empty cycles.
        rx_q.push_back(8'h81);
        drive_rx();
        tick();
        exp_pops += 1;
        repeat (TO_CYC) tick();
        check("to_wait_nopush", 64'(tx_q.size()), 64'(chk_idx));
        check("to_wait_busy", 64'(busy), 64'(1));
        tick();
        check("to_push", 64'(tx_q.size()), 64'(chk_idx + 1));
        add_exp(8'h81, 8'h00, 1'b0, 8'h15);
        run_until(exp_q.size(), k);
        checkOutput("timeout", 8'd6);

        // Data byte arriving on the terminal-count cycle still completes the write.
        rx_q.push_back(8'h81);
        drive_rx();
        tick();
        exp_pops += 1;
        repeat (TO_CYC - 1) tick();
        check("tcdata_nopush", 64'(tx_q.size()), 64'(chk_idx));
        rx_q.push_back(8'h44);
        drive_rx();
        exp_pops += 1;
        add_exp(8'h81, 8'h44, 1'b1, 8'h06);
        model_regs[8*1 +: 8] = 8'h44;
        run_until(exp_q.size(), k);
        checkOutput("tc_data", 8'd6);

        // Reset while waiting for a write's data byte.
        rx_q.push_back(8'h82);
        drive_rx();
        tick();
        exp_pops += 1;
        check("midrst_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_regs = '0;
        check("midrst_regs", 64'(regs_q), 64'(0));
        check("midrst_err", 64'(err_cnt), 64'(0));
        check("midrst_busy0", 64'(busy), 64'(0));
        check("midrst_tx", 64'(tx_q.size()), 64'(chk_idx));
        run_cmd("post_rst_read", '{8'h03, 8'h00, 1'b0, 8'h00, 8'd0});

        check("no_pop_push_overlap", 64'(overlap_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
